// File: rtl/seq_alu_if.sv
// Operation/result handshake bundle for seq_alu: master offers ops and consumes results.
interface seq_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, alu_ctr, out_ready,
    input  in_ready, out_valid, res, zero, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, alu_ctr, out_ready,
    output in_ready, out_valid, res, zero, overflow, busy
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift/compare plus optional iterative
// mul/div, built only when SEQ_ALU_MULDIV_EN is defined.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [1:0] ITER = 2'd1;
`endif
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] res_p1;
  logic             zero_p1;
  logic             ovf_p1;
  logic             vld_p1;
  logic             accept;
  logic [WIDTH:0]   alu_out;

  // Returns {overflow, result}; mul/div encodings fall to the zero default.
  function automatic logic [WIDTH:0] alu_calc(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [3:0] op);
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        r;
    logic                    v;
    xs = x;
    ys = y;
    sh = x[SHW-1:0];
    r  = '0;
    v  = 1'b0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: begin
        r = x + y;
        v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      4'b0011: r = x ^ y;
      4'b0100: r = ~(x | y);
      4'b0101: r = y >> sh;
      4'b0110: begin
        r = x - y;
        v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      4'b0111: r = {{(WIDTH-1){1'b0}}, x < y};
      4'b1000: r = y << sh;
      4'b1001: r = ys >>> sh;
      4'b1010: r = {{(WIDTH-1){1'b0}}, xs < ys};
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  assign vld_p1        = (state == DONE);
  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign alu_out       = alu_calc(bus.a, bus.b, bus.alu_ctr);
  assign bus.out_valid = vld_p1;
  assign bus.res       = res_p1;
  assign bus.zero      = zero_p1;
  assign bus.overflow  = ovf_p1;

`ifdef SEQ_ALU_MULDIV_EN
  logic [SHW:0]     cnt;
  logic [3:0]       op_p1;
  logic [WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0] quo_p1;
  logic [WIDTH-1:0] opnd_p1;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] fin;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dshift;
  logic [WIDTH:0]   dtrial;
  logic             is_iter;
  logic             mul_in;
  logic             mul_p1;
  logic             last;

  assign mul_in  = (bus.alu_ctr == 4'b1011) | (bus.alu_ctr == 4'b1100);
  assign is_iter = mul_in | (bus.alu_ctr == 4'b1101) | (bus.alu_ctr == 4'b1110);
  assign mul_p1  = (op_p1 == 4'b1011) | (op_p1 == 4'b1100);
  assign last    = (cnt == (SHW+1)'(WIDTH-1));
  assign bus.busy = (state == ITER);

  // mul: {acc,quo} is the shifting product, quo starts as the multiplier.
  // div: acc is the partial remainder, quo shifts dividend bits out and quotient bits in.
  always_comb begin
    msum   = {1'b0, acc_p1} + (quo_p1[0] ? {1'b0, opnd_p1} : '0);
    dshift = {acc_p1, quo_p1[WIDTH-1]};
    dtrial = dshift - {1'b0, opnd_p1};
    acc_nxt = '0;
    quo_nxt = '0;
    if (mul_p1) begin
      acc_nxt = msum[WIDTH:1];
      quo_nxt = {msum[0], quo_p1[WIDTH-1:1]};
    end else if (!dtrial[WIDTH]) begin
      acc_nxt = dtrial[WIDTH-1:0];
      quo_nxt = {quo_p1[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = dshift[WIDTH-1:0];
      quo_nxt = {quo_p1[WIDTH-2:0], 1'b0};
    end
    // Odd encodings (mul, divu) take the low/quotient half, even ones the high/remainder.
    fin = op_p1[0] ? quo_nxt : acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (accept && is_iter) begin
      op_p1   <= bus.alu_ctr;
      acc_p1  <= '0;
      opnd_p1 <= mul_in ? bus.a : bus.b;
      quo_p1  <= mul_in ? bus.b : bus.a;
    end else if (state == ITER) begin
      acc_p1 <= acc_nxt;
      quo_p1 <= quo_nxt;
    end
  end
`else
  assign bus.busy = 1'b0;
`endif

  // ---- result stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      cnt     <= '0;
`endif
    end else if (accept) begin
`ifdef SEQ_ALU_MULDIV_EN
      if (is_iter) begin
        state <= ITER;
        cnt   <= '0;
      end else
`endif
      begin
        state   <= DONE;
        res_p1  <= alu_out[WIDTH-1:0];
        zero_p1 <= (alu_out[WIDTH-1:0] == '0);
        ovf_p1  <= alu_out[WIDTH];
      end
    end
`ifdef SEQ_ALU_MULDIV_EN
    else if (state == ITER) begin
      if (last) begin
        state   <= DONE;
        res_p1  <= fin;
        zero_p1 <= (fin == '0);
        ovf_p1  <= 1'b0;
      end else begin
        cnt <= cnt + (SHW+1)'(1);
      end
    end
`endif
    else if ((state == DONE) && bus.out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu; mul/div scenarios follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus ();
  seq_alu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    bus.alu_ctr  = op;
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.alu_ctr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.res !== 32'h0) begin errors++; $display("FAIL rst_res got %h exp 0", bus.res); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL rst_zero got %b exp 0", bus.zero); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", bus.overflow); end
    bus.a = 32'h1234; bus.b = 32'h1; bus.alu_ctr = 4'b0010;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_valid got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_add_sub();
    bus.out_ready = 1'b1;
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.res !== 32'h8000_0000) begin errors++; $display("FAIL add_res got %h exp 80000000", bus.res); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL add_ovf got %b exp 1", bus.overflow); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b exp 0", bus.zero); end
    issue(4'b0110, 32'h5, 32'h5);
    checks++; if (bus.res !== 32'h0) begin errors++; $display("FAIL sub_res got %h exp 0", bus.res); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL sub_zero got %b exp 1", bus.zero); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL sub_ovf got %b exp 0", bus.overflow); end
    issue(4'b0110, 32'h8000_0000, 32'h1);
    checks++; if (bus.res !== 32'h7FFF_FFFF) begin errors++; $display("FAIL subov_res got %h exp 7fffffff", bus.res); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL subov_ovf got %b exp 1", bus.overflow); end
    issue(4'b0010, 32'hFFFF_FFFF, 32'h1);
    checks++; if (bus.res !== 32'h0) begin errors++; $display("FAIL addwrap_res got %h exp 0", bus.res); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL addwrap_ovf got %b exp 0", bus.overflow); end
  endtask

  task automatic test_logic();
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if (bus.res !== 32'h0000_F000) begin errors++; $display("FAIL and_res got %h exp 0000f000", bus.res); end
    issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if (bus.res !== 32'h0000_FFF0) begin errors++; $display("FAIL or_res got %h exp 0000fff0", bus.res); end
    issue(4'b0011, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if (bus.res !== 32'h0000_0FF0) begin errors++; $display("FAIL xor_res got %h exp 00000ff0", bus.res); end
    issue(4'b0100, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if (bus.res !== 32'hFFFF_000F) begin errors++; $display("FAIL nor_res got %h exp ffff000f", bus.res); end
  endtask

  task automatic test_shift_cmp();
    issue(4'b1001, 32'h24, 32'hF000_0000);
    checks++; if (bus.res !== 32'hFF00_0000) begin errors++; $display("FAIL sra_res got %h exp ff000000", bus.res); end
    issue(4'b0101, 32'h24, 32'hF000_0000);
    checks++; if (bus.res !== 32'h0F00_0000) begin errors++; $display("FAIL srl_res got %h exp 0f000000", bus.res); end
    issue(4'b1000, 32'h24, 32'hF000_0001);
    checks++; if (bus.res !== 32'h0000_0010) begin errors++; $display("FAIL sll_res got %h exp 00000010", bus.res); end
    issue(4'b1010, 32'hFFFF_FFFF, 32'h1);
    checks++; if (bus.res !== 32'h1) begin errors++; $display("FAIL slt_res got %h exp 1", bus.res); end
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1);
    checks++; if (bus.res !== 32'h0) begin errors++; $display("FAIL sltu_res got %h exp 0", bus.res); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL sltu_zero got %b exp 1", bus.zero); end
    issue(4'b1111, 32'h5, 32'h6);
    checks++; if (bus.res !== 32'h0) begin errors++; $display("FAIL rsvd_res got %h exp 0", bus.res); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rsvd_valid got %b exp 1", bus.out_valid); end
  endtask

`ifdef SEQ_ALU_MULDIV_EN
  task automatic test_muldiv();
    logic [3:0]  ops  [4];
    logic [31:0] opa  [4];
    logic [31:0] opb  [4];
    logic [31:0] exps [4];
    int bad;
    bus.out_ready = 1'b1;
    issue(4'b1011, 32'h0001_0000, 32'h0003_0000);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mul_iter_flags got %0d bad cycles exp 0", bad); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mul_latency got %b exp 1", bus.out_valid); end
    checks++; if (bus.res !== 32'h0) begin errors++; $display("FAIL mul_res got %h exp 0", bus.res); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_done got %b exp 0", bus.busy); end
    ops[0] = 4'b1100; opa[0] = 32'h0001_0000; opb[0] = 32'h0003_0000; exps[0] = 32'h3;
    ops[1] = 4'b1101; opa[1] = 32'd100;       opb[1] = 32'd0;         exps[1] = 32'hFFFF_FFFF;
    ops[2] = 4'b1110; opa[2] = 32'd100;       opb[2] = 32'd7;         exps[2] = 32'd2;
    ops[3] = 4'b1110; opa[3] = 32'd100;       opb[3] = 32'd0;         exps[3] = 32'd100;
    for (int k = 0; k < 4; k++) begin
      issue(ops[k], opa[k], opb[k]);
      for (int t = 0; t < 40 && bus.out_valid !== 1'b1; t++) begin
        @(posedge clk); #1;
      end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL md%0d_timeout got %b exp 1", k, bus.out_valid); end
      checks++; if (bus.res !== exps[k]) begin errors++; $display("FAIL md%0d_res got %h exp %h", k, bus.res, exps[k]); end
    end
  endtask
`else
  task automatic test_muldiv();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] op;
      op = 4'(4'b1011 + k);
      issue(op, 32'h0001_0000, 32'h0003_0000);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL nomd%0d_valid got %b exp 1", k, bus.out_valid); end
      checks++; if (bus.res !== 32'h0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0 || bus.busy !== 1'b0)
        begin errors++; $display("FAIL nomd%0d_res got res=%h z=%b v=%b busy=%b exp 0/1/0/0", k, bus.res, bus.zero, bus.overflow, bus.busy); end
    end
  endtask
`endif

  task automatic test_hold();
    int bad;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(4'b0011, 32'hA5, 32'h0F);
    checks++; if (bus.res !== 32'hAA) begin errors++; $display("FAIL hold_first got %h exp aa", bus.res); end
    bus.alu_ctr = 4'b0010; bus.a = 32'h1; bus.b = 32'h1; bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.res !== 32'hAA || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles exp 0", bad); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.res !== 32'h2) begin errors++; $display("FAIL hold_release got %h exp 2", bus.res); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops  [4];
    logic [31:0] opa  [4];
    logic [31:0] opb  [4];
    logic [31:0] exps [4];
    ops[0] = 4'b0010; opa[0] = 32'd3;    opb[0] = 32'd4;    exps[0] = 32'd7;
    ops[1] = 4'b0011; opa[1] = 32'hF0;   opb[1] = 32'hFF;   exps[1] = 32'h0F;
    ops[2] = 4'b1000; opa[2] = 32'd8;    opb[2] = 32'd1;    exps[2] = 32'h100;
    ops[3] = 4'b0001; opa[3] = 32'h10;   opb[3] = 32'h01;   exps[3] = 32'h11;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.alu_ctr = ops[k]; bus.a = opa[k]; bus.b = opb[k]; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.res !== exps[k])
        begin errors++; $display("FAIL b2b%0d got v=%b res=%h exp v=1 res=%h", k, bus.out_valid, bus.res, exps[k]); end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(4'b0010, 32'd2, 32'd3);
    checks++; if (bus.res !== 32'd5) begin errors++; $display("FAIL rmid_pre got %h exp 5", bus.res); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0 || bus.res !== 32'h0 || bus.zero !== 1'b0)
      begin errors++; $display("FAIL rmid_held got v=%b res=%h z=%b exp 0/0/0", bus.out_valid, bus.res, bus.zero); end
`ifdef SEQ_ALU_MULDIV_EN
    begin
      int bad;
      bus.out_ready = 1'b1;
      issue(4'b1101, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b exp 1", bus.busy); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
        begin errors++; $display("FAIL rmid_div got v=%b busy=%b rdy=%b exp 0/0/1", bus.out_valid, bus.busy, bus.in_ready); end
      bad = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (bus.out_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rmid_noresult got %0d valid cycles exp 0", bad); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_shift_cmp();
    test_muldiv();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
